// File: rtl/dff_unit_pkg.sv
// ============================================================================
// Module   : dff_unit_pkg
// Brief    : Shared constants for the dff_unit register slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dff_unit_pkg;

  localparam int          c_DEFAULT_WIDTH   = 1;
  localparam int          c_MAX_WIDTH       = 64;
  localparam logic [63:0] c_DEFAULT_RST_VAL = 64'h0;

endpackage : dff_unit_pkg

`default_nettype wire

// File: rtl/dff_unit_bit.sv
// ============================================================================
// Module   : dff_unit_bit
// Brief    : One-bit enabled D flop with asynchronous active-high reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dff_unit_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic C,
  input  logic R,
  input  logic D,
  input  logic E,
  output logic Q
);

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      Q <= RST_VAL;
    end else if (E) begin
      Q <= D;
    end
  end

endmodule : dff_unit_bit

`default_nettype wire

// File: rtl/dff_unit.sv
// ============================================================================
// Module   : dff_unit
// Brief    : WIDTH-bit enabled register with registered change flag.
//            Define DFF_UNIT_QN_EN to add the complemented output QN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dff_unit
  import dff_unit_pkg::*;
#(
  parameter int               WIDTH   = c_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(c_DEFAULT_RST_VAL)
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic             E,
  output logic [WIDTH-1:0] Q,
`ifdef DFF_UNIT_QN_EN
  output logic [WIDTH-1:0] QN,
`endif
  output logic             CHG
);

  logic [WIDTH-1:0] w_q;
  logic             r_chg;

  if (WIDTH < 1 || WIDTH > c_MAX_WIDTH) begin : g_width_check
    $error("dff_unit: WIDTH=%0d outside legal range 1..%0d", WIDTH, c_MAX_WIDTH);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    dff_unit_bit #(
      .RST_VAL (RST_VAL[i])
    ) u_bit (
      .C (C),
      .R (R),
      .D (D[i]),
      .E (E),
      .Q (w_q[i])
    );
  end

  // Compare against the pre-edge Q so a flag only marks a real value change.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_chg <= 1'b0;
    end else begin
      r_chg <= E && (D != w_q);
    end
  end

  assign Q   = w_q;
  assign CHG = r_chg;

`ifdef DFF_UNIT_QN_EN
  assign QN = ~w_q;
`endif

endmodule : dff_unit

`default_nettype wire

// File: tb/tb_dff_unit.sv
// ============================================================================
// Module   : tb_dff_unit
// Brief    : Directed, table-driven bench for dff_unit (QN checks when
//            DFF_UNIT_QN_EN is defined).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dff_unit;

  int n_pass  = 0;
  int n_total = 0;

  // 1-bit instance with a hand-driven clock
  logic       c1 = 1'b0;
  logic       r1 = 1'b0;
  logic       e1 = 1'b1;
  logic       d1 = 1'b0;
  logic       q1, chg1;

  // 8-bit and 4-bit instances share a free-running clock
  logic       clk = 1'b0;
  logic       r8  = 1'b1;
  logic       e8  = 1'b0;
  logic [7:0] d8  = 8'h00;
  logic [7:0] q8;
  logic       chg8;

  logic       r4  = 1'b1;
  logic       e4  = 1'b0;
  logic [3:0] d4  = 4'h0;
  logic [3:0] q4;
  logic       chg4;

`ifdef DFF_UNIT_QN_EN
  logic       qn1;
  logic [7:0] qn8;
  logic [3:0] qn4;
`endif

  always #5 clk = ~clk;

  dff_unit #(.WIDTH(1)) u_dut1 (
    .C   (c1),
    .R   (r1),
    .D   (d1),
    .E   (e1),
    .Q   (q1),
`ifdef DFF_UNIT_QN_EN
    .QN  (qn1),
`endif
    .CHG (chg1)
  );

  dff_unit #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut8 (
    .C   (clk),
    .R   (r8),
    .D   (d8),
    .E   (e8),
    .Q   (q8),
`ifdef DFF_UNIT_QN_EN
    .QN  (qn8),
`endif
    .CHG (chg8)
  );

  dff_unit #(.WIDTH(4), .RST_VAL(4'h0)) u_dut4 (
    .C   (clk),
    .R   (r4),
    .D   (d4),
    .E   (e4),
    .Q   (q4),
`ifdef DFF_UNIT_QN_EN
    .QN  (qn4),
`endif
    .CHG (chg4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       e;
    logic [7:0] d;
    logic [7:0] q;
    logic       chg;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // enable/hold/change-flag sequence starting from RST_VAL=A5
    vecs[0]  = '{e: 1'b0, d: 8'h3C, q: 8'hA5, chg: 1'b0};
    vecs[1]  = '{e: 1'b0, d: 8'h3C, q: 8'hA5, chg: 1'b0};
    vecs[2]  = '{e: 1'b1, d: 8'h3C, q: 8'h3C, chg: 1'b1};
    vecs[3]  = '{e: 1'b1, d: 8'h3C, q: 8'h3C, chg: 1'b0};
    vecs[4]  = '{e: 1'b1, d: 8'hFF, q: 8'hFF, chg: 1'b1};
    vecs[5]  = '{e: 1'b0, d: 8'h00, q: 8'hFF, chg: 1'b0};
    vecs[6]  = '{e: 1'b1, d: 8'h00, q: 8'h00, chg: 1'b1};
    vecs[7]  = '{e: 1'b1, d: 8'hA5, q: 8'hA5, chg: 1'b1};
    vecs[8]  = '{e: 1'b1, d: 8'h5A, q: 8'h5A, chg: 1'b1};
    vecs[9]  = '{e: 1'b1, d: 8'h5A, q: 8'h5A, chg: 1'b0};
    vecs[10] = '{e: 1'b1, d: 8'hC3, q: 8'hC3, chg: 1'b1};

    // 1-bit plain DFF timing: rise at t=5, D changes at t=10 while C high
    #5  c1 = 1'b1;
    #1  check("w1_first_edge_q", 64'(q1), 64'h0);
    #4  d1 = 1'b1;
    #1  check("w1_d_change_c_high", 64'(q1), 64'h0);
    #9  c1 = 1'b0;
    #1  check("w1_falling_edge", 64'(q1), 64'h0);
    #4  c1 = 1'b1;
    #1  check("w1_second_edge_q", 64'(q1), 64'h1);
    check("w1_second_edge_chg", 64'(chg1), 64'h1);
`ifdef DFF_UNIT_QN_EN
    check("w1_qn", 64'(qn1), 64'h0);
`endif

    // reset state of the wider instances
    @(negedge clk);
    check("w8_reset_q", 64'(q8), 64'hA5);
    check("w8_reset_chg", 64'(chg8), 64'h0);
`ifdef DFF_UNIT_QN_EN
    check("w4_reset_qn", 64'(qn4), 64'hF);
`endif
    r8 = 1'b0;
    r4 = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      e8 = vecs[i].e;
      d8 = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_q", i), 64'(q8), 64'(vecs[i].q));
      check($sformatf("vec%0d_chg", i), 64'(chg8), 64'(vecs[i].chg));
`ifdef DFF_UNIT_QN_EN
      check($sformatf("vec%0d_qn", i), 64'(qn8), 64'(~vecs[i].q));
`endif
    end

    // mid-cycle reset: immediate effect, edges ignored while held
    @(negedge clk);
    #2 r8 = 1'b1;
    #1 check("midreset_q", 64'(q8), 64'hA5);
    check("midreset_chg", 64'(chg8), 64'h0);
    e8 = 1'b1;
    d8 = 8'h11;
    @(posedge clk);
    @(posedge clk);
    #1 check("reset_ignores_edges_q", 64'(q8), 64'hA5);
    check("reset_ignores_edges_chg", 64'(chg8), 64'h0);
    @(negedge clk);
    r8 = 1'b0;
    @(posedge clk);
    #1 check("post_reset_capture_q", 64'(q8), 64'h11);
    check("post_reset_capture_chg", 64'(chg8), 64'h1);

    // D toggled on falling edges only; Q moves on rising edges only
    begin
      logic [7:0] seq [3];
      logic [7:0] prev;
      seq[0] = 8'h01;
      seq[1] = 8'h80;
      seq[2] = 8'h7E;
      prev = 8'h11;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        d8 = seq[i];
        #1 check($sformatf("fall%0d_hold_q", i), 64'(q8), 64'(prev));
        @(posedge clk);
        #1 check($sformatf("rise%0d_q", i), 64'(q8), 64'(seq[i]));
        d8 = ~seq[i];
        #1 check($sformatf("rise%0d_c_high_q", i), 64'(q8), 64'(seq[i]));
        prev = seq[i];
      end
    end

    // 4-bit instance capture of 1010
    @(negedge clk);
    e4 = 1'b1;
    d4 = 4'b1010;
    @(posedge clk);
    #1 check("w4_q", 64'(q4), 64'hA);
    check("w4_chg", 64'(chg4), 64'h1);
`ifdef DFF_UNIT_QN_EN
    check("w4_qn", 64'(qn4), 64'h5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dff_unit

`default_nettype wire

// File: doc/dff_unit.md
DFF_UNIT -- requirements
Module: dff_unit

Interface
REQ-001 Parameter WIDTH, default 1, data width in bits; legal range 1..64.
REQ-002 Parameter RST_VAL, default 0 (WIDTH bits), value loaded into Q on reset.
REQ-003 C  input  1  clock; all state changes on its rising edge only.
REQ-004 R  input  1  reset; asynchronous, active-high.
REQ-005 D  input  WIDTH  data captured at the rising edge of C.
REQ-006 E  input  1  capture enable; active-high; tie to 1 for plain-DFF use.
REQ-007 Q  output  WIDTH  registered data.
REQ-008 CHG  output  1  registered flag, high for one cycle after a capture that changed Q.
REQ-009 QN  output  WIDTH  bitwise complement of Q; present only when DFF_UNIT_QN_EN is defined.

Function
REQ-010 At each rising edge of C with R low and E high, Q SHALL take the value of D; latency one edge.
REQ-011 With E low at a rising edge, Q SHALL hold its previous value.
REQ-012 Q SHALL NOT change on the falling edge of C, nor on any change of D or E while C is stable (high or low).
REQ-013 CHG SHALL be high for exactly the cycle after an edge where E=1 and D differs from the prior Q; otherwise low.
REQ-014 Repeated captures of an identical value SHALL leave CHG low.
REQ-015 When D changes in the same time step as the rising edge of C, the value present before the edge SHALL be captured (no race in RTL; nonblocking assignments).
REQ-016 Q and CHG SHALL be driven directly from flops; no combinational path from D, E to Q or CHG.
REQ-017 For WIDTH=1 the module SHALL behave as a plain edge-triggered D flip-flop (ports D, C, Q sufficient, E tied high, R tied low).

Reset
REQ-018 R high SHALL force Q=RST_VAL and CHG=0 immediately, independent of C.
REQ-019 While R is high, rising edges of C SHALL be ignored.
REQ-020 After R deasserts, the first rising edge of C SHALL capture normally; CHG compares against RST_VAL.
REQ-021 Reset asserted mid-operation SHALL override any pending capture in the same time step.

Configuration
REQ-022 Macro DFF_UNIT_QN_EN: when defined, QN port exists and equals ~Q at all times (including reset: ~RST_VAL); when undefined, QN port and logic are absent and all other behaviour is unchanged.

Structure
REQ-023 Package dff_unit_pkg SHALL hold the default width constant, the maximum width constant (64) and the default reset value constant.
REQ-024 A sub-module dff_unit_bit (one-bit flop with C, R, D, E, reset value, Q) SHALL be instantiated WIDTH times via generate; change detection and QN reside in the top.
REQ-025 A parameter check SHALL raise an elaboration error for WIDTH outside 1..64.

Verification
REQ-026 WIDTH=1, R=0, E=1: D=0, C=0 at t=0; C rises at t=5 with D=0 -> Q=0; D goes 1 at t=10 with C held 1 -> Q stays 0 until the next rising edge, then Q=1.
REQ-027 WIDTH=8, RST_VAL=8'hA5: assert R between clock edges -> Q=8'hA5 and CHG=0 immediately; edges during R ignored.
REQ-028 WIDTH=8: E=0, D=8'h3C, two edges -> Q unchanged, CHG=0; E=1 at next edge -> Q=8'h3C, CHG=1 for one cycle.
REQ-029 Same value 8'h3C captured again with E=1 -> Q=8'h3C, CHG=0.
REQ-030 D toggled at falling edges only, E=1 -> Q updates solely at rising edges with the value held across each rising edge.
REQ-031 With DFF_UNIT_QN_EN defined, WIDTH=4: Q=4'b1010 -> QN=4'b0101; during reset with RST_VAL=0 -> QN=4'b1111.
